// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with two modes: direct decode via a
// valid/ready handshake, or scan mode that walks one active bit with a programmable dwell.
module onehot_decoder_seq #(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 2**SEL_W,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   sel_q,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               valid_d;
    logic               wrap_d;
    logic [OUT_W-1:0]   out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_q     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sel_q     <= sel_d;
            out_valid <= valid_d;
            out       <= out_d;
            wrap      <= wrap_d;
        end
    end

    // enable dominates; otherwise mode alone selects the active state.
    always_comb begin
        state_d = state;
        if (!enable)
            state_d = IDLE;
        else if (mode)
            state_d = SCAN;
        else
            state_d = DIRECT;
    end

    assign in_ready = (state == DIRECT) && enable && !mode;

    always_comb begin
        sel_d   = sel_q;
        valid_d = out_valid;
        cnt_d   = cnt;
        wrap_d  = 1'b0;
        case (state_d)
            IDLE: begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end
            DIRECT: begin
                cnt_d = '0;
                if (in_ready && in_valid) begin
                    sel_d   = in;
                    valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (state != SCAN) begin
                    sel_d   = '0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt >= dwell) begin
                    cnt_d  = '0;
                    sel_d  = sel_q + 1'b1;
                    wrap_d = &sel_q;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
        // out is derived from the next-state index so the one-hot invariant holds by construction.
        out_d = valid_d ? ({{(OUT_W-1){1'b0}}, 1'b1} << sel_d) : '0;
    end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder. It is the clocked successor to the team's combinational 4-to-16 decoder. Two modes:
- Direct: decodes a select accepted through a valid/ready handshake.
- Scan: walks the active bit across all outputs with a programmable dwell time.
It drives chip-select, row-strobe and LED-scan style loads. Outputs are always zero or one-hot; the block never tristates.

Parameters:
SEL_W, 4, select width in bits.
OUT_W, 2**SEL_W, number of one-hot outputs. Derived; must not be overridden.
DWELL_W, 8, width of the scan dwell-count input.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  block enable; low forces IDLE.
mode  input  1  0 = direct decode, 1 = scan.
in_valid  input  1  select valid (direct mode).
in_ready  output  1  block can accept a select.
in  input  SEL_W  binary select.
dwell  input  DWELL_W  extra cycles each scan position is held.
out  output  OUT_W  one-hot output, or all zero.
out_valid  output  1  out holds a one-hot value.
sel_q  output  SEL_W  index of the currently active bit.
wrap  output  1  one-cycle pulse when scan wraps to index 0.

Behaviour:
- Reset (async assert, any cycle): state=IDLE; out=0; out_valid=0; sel_q=0; wrap=0; dwell counter=0.
- All outputs are registered except in_ready, which is decoded from state and enable.
- Invariant: out == (out_valid ? 1<<sel_q : 0) on every cycle.
- States: IDLE, DIRECT, SCAN.
- IDLE:
  - out=0, out_valid=0, in_ready=0.
  - enable=1 moves to DIRECT if mode=0, or to SCAN if mode=1, on the next edge.
- Priority: enable=0 dominates. From DIRECT or SCAN, enable=0 moves to IDLE, and out/out_valid are 0 after that edge. sel_q holds its value.
- DIRECT:
  - in_ready = enable. A transfer occurs when in_valid && in_ready.
  - Latency 1: the edge that accepts `in` loads sel_q=in, out=1<<in, out_valid=1.
  - Without a transfer, out/sel_q/out_valid hold.
  - First entry from IDLE: out_valid=0 until the first transfer.
  - in_valid with in_ready=0 is ignored; nothing is queued.
- DIRECT -> SCAN when mode=1 (enable=1). The transition edge loads sel_q=0, out=1, out_valid=1, counter=0. Any in_valid on that cycle is ignored, because in_ready=0 when mode=1.
- SCAN:
  - in_ready=0.
  - Each cycle: if counter >= dwell, then counter<=0, sel_q<=sel_q+1 (modulo OUT_W), out follows. Otherwise counter<=counter+1.
  - Each position is held dwell+1 cycles. dwell=0 advances every cycle.
  - dwell is sampled live. Lowering dwell below the current count advances on the next edge.
  - wrap=1 for exactly the one cycle in which sel_q has just become 0 from OUT_W-1; otherwise wrap=0.
  - Entry from IDLE: same loading as entry from DIRECT (sel_q=0, out=1, out_valid=1, counter=0).
- SCAN -> DIRECT when mode=0 (enable=1). out, sel_q and out_valid hold the last scan value until the next direct transfer. Counter clears.
- wrap is forced 0 outside SCAN.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). After deassertion the block restarts from IDLE; no in-flight transfer survives.
- `in` is always in range (2**SEL_W == OUT_W); there is no x/z output path.

Test Plan:
1. Reset check: assert rst with enable=1, mode=1 mid-scan -> out=16'h0000, out_valid=0, sel_q=0, wrap=0 asynchronously; state IDLE after release.
2. Direct decode: enable=1, mode=0, in=4'hA with in_valid=1 for one cycle -> next edge gives out=16'h0400, sel_q=10, out_valid=1; value holds with in_valid=0.
3. Back-to-back direct transfers 0,15,7 on consecutive cycles -> out = 16'h0001, 16'h8000, 16'h0080 on consecutive cycles. With enable=0, in_valid=1, in=3 -> in_ready=0 and out stays 0.
4. Scan with dwell=2 -> each bit held 3 cycles, order 0x0001..0x8000. wrap pulses once, 48 cycles after scan entry, exactly as out returns to 16'h0001. Repeat with dwell=0 -> wrap every 16 cycles.
5. Mid-scan events:
   - Drop enable at sel_q=5 -> out=0, out_valid=0 next edge, sel_q=5.
   - Re-enable -> scan restarts at sel_q=0.
   - Lower dwell 200->1 mid-hold -> advance on the next edge.
6. Mode switches:
   - SCAN->DIRECT holds the current one-hot.
   - DIRECT->SCAN with in_valid=1 on the same cycle -> in ignored, out=16'h0001.
   - Throughout, checker asserts the one-hot/zero invariant every cycle.
